// File: rtl/nor_flash_responder.sv
// Byte-wide NOR flash responder: a 256-byte Intel-style command-set device on the NF_* pins.
// All pins are resynchronized to CLK_50MHZ. Writes are decoded on the synchronized NF_WE
// rising edge. Reads return a registered byte that follows the synchronized address.
module nor_flash_responder #(
    parameter int unsigned PROG_CYCLES  = 50,
    parameter int unsigned ERASE_CYCLES = 1000,
    parameter logic [7:0]  MFR_ID       = 8'h89,
    parameter logic [7:0]  DEV_ID       = 8'h16
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [7:0] NF_A,
    inout  wire  [7:0] NF_D,
    input  logic       NF_CE,
    input  logic       NF_OE,
    input  logic       NF_WE,
    input  logic       NF_RP,
    input  logic       NF_WP,
    input  logic       NF_BYTE,
    output logic       NF_STS
);

    typedef enum logic [2:0] {
        StReadArray,
        StReadStatus,
        StReadId,
        StProgSetup,
        StEraseSetup,
        StBusyProg,
        StBusyErase
    } mode_e;

    // One bundle so every sampled pin sees exactly the same synchronizer delay.
    typedef struct packed {
        logic       rp;
        logic       wp;
        logic       we;
        logic       ce;
        logic [7:0] a;
        logic [7:0] d;
    } pins_t;

    localparam pins_t PinsIdle = '{rp: 1'b1, wp: 1'b1, we: 1'b1, ce: 1'b1, a: 8'h00, d: 8'h00};
    localparam logic [31:0] ProgLoad  = 32'(PROG_CYCLES);
    localparam logic [31:0] EraseLoad = 32'(ERASE_CYCLES);
    // The erase walk is active while the counter is above this value: the first 256 busy clocks.
    localparam logic [31:0] WalkEnd   = 32'(ERASE_CYCLES - 256);

    pins_t       pins_raw;
    pins_t       s1_q, s2_q, prev_q;
    mode_e       mode_q, mode_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        perr_q, perr_d;
    logic        eerr_q, eerr_d;
    logic [7:0]  rd_q, rd_d;
    // Power-up content of an erased device; RST never touches the array.
    logic [7:0]  mem_q [256] = '{default: 8'hFF};
    logic        mem_we;
    logic [7:0]  mem_waddr, mem_wdata;
    logic        busy, rst_any, wr_evt, walk_act, oe_en;
    logic [7:0]  sr;
    logic        unused_pins;

    assign pins_raw = {NF_RP, NF_WP, NF_WE, NF_CE, NF_A, NF_D};
    assign unused_pins = ^{NF_BYTE, prev_q.rp};

    // NF_RP low acts as a reset of everything past the synchronizer.
    assign rst_any  = RST | ~s2_q.rp;
    assign wr_evt   = s2_q.we & ~prev_q.we & ~prev_q.ce;
    assign busy     = (mode_q == StBusyProg) || (mode_q == StBusyErase);
    assign walk_act = (cnt_q > WalkEnd);
    assign sr       = {~busy, 1'b0, eerr_q, perr_q, 4'h0};

    // Two-flop synchronizer plus one more sample for edge detection and write operands.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            s1_q   <= PinsIdle;
            s2_q   <= PinsIdle;
            prev_q <= PinsIdle;
        end else begin
            s1_q   <= pins_raw;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Mode, busy counter, walk pointer, error bits and memory write port.
    always_comb begin
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        perr_d    = perr_q;
        eerr_d    = eerr_q;
        mem_we    = 1'b0;
        mem_waddr = prev_q.a;
        mem_wdata = mem_q[prev_q.a] & prev_q.d;

        case (mode_q)
            StReadArray, StReadStatus, StReadId: begin
                if (wr_evt) begin
                    case (prev_q.d)
                        8'hFF:        mode_d = StReadArray;
                        8'h70:        mode_d = StReadStatus;
                        8'h90:        mode_d = StReadId;
                        8'h50: begin
                            perr_d = 1'b0;
                            eerr_d = 1'b0;
                        end
                        8'h40, 8'h10: mode_d = StProgSetup;
                        8'h20:        mode_d = StEraseSetup;
                        default:      ;
                    endcase
                end
            end
            StProgSetup: begin
                if (wr_evt) begin
                    if (!prev_q.wp) begin
                        perr_d = 1'b1;
                        mode_d = StReadStatus;
                    end else begin
                        // Programming can only clear bits.
                        mem_we = 1'b1;
                        cnt_d  = ProgLoad;
                        mode_d = StBusyProg;
                    end
                end
            end
            StEraseSetup: begin
                if (wr_evt) begin
                    if (prev_q.d == 8'hD0) begin
                        if (prev_q.wp) begin
                            cnt_d  = EraseLoad;
                            mode_d = StBusyErase;
                        end else begin
                            eerr_d = 1'b1;
                            mode_d = StReadStatus;
                        end
                    end else begin
                        eerr_d = 1'b1;
                        perr_d = 1'b1;
                        mode_d = StReadStatus;
                    end
                end
            end
            StBusyProg, StBusyErase: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    mode_d = StReadStatus;
                end
                if (mode_q == StBusyErase && walk_act) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = 8'hFF;
                    ptr_d     = ptr_q + 8'd1;
                end
            end
            default: mode_d = StReadArray;
        endcase

        if (rst_any) begin
            mem_we = 1'b0;
        end
    end

    // Read data follows the synchronized address and current mode.
    always_comb begin
        rd_d = sr;
        case (mode_q)
            StReadArray: rd_d = mem_q[s2_q.a];
            StReadId: begin
                if (s2_q.a == 8'd0) begin
                    rd_d = MFR_ID;
                end else if (s2_q.a == 8'd1) begin
                    rd_d = DEV_ID;
                end else begin
                    rd_d = 8'h00;
                end
            end
            default: rd_d = sr;
        endcase
    end

    // Control state; RST or a synchronized NF_RP low overrides any pending update.
    always_ff @(posedge CLK_50MHZ) begin
        if (rst_any) begin
            mode_q <= StReadArray;
            cnt_q  <= '0;
            ptr_q  <= '0;
            perr_q <= 1'b0;
            eerr_q <= 1'b0;
            rd_q   <= 8'hFF;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            perr_q <= perr_d;
            eerr_q <= eerr_d;
            rd_q   <= rd_d;
        end
    end

    // Single write port into the array.
    always_ff @(posedge CLK_50MHZ) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Output enable comes straight from the raw pins so the bus releases without delay.
    assign oe_en  = ~RST & ~NF_CE & ~NF_OE & NF_WE & NF_RP;
    assign NF_D   = oe_en ? rd_q : 8'hzz;
    assign NF_STS = ~busy;

endmodule

// File: tb/tb_nor_flash_responder.sv
// Self-checking bench for nor_flash_responder against a byte-array reference model.
module tb_nor_flash_responder;

    localparam int unsigned ProgCycles  = 50;
    localparam int unsigned EraseCycles = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        ce, oe, we, rp, wp, byte_n;
    logic        drv_en;
    logic [7:0]  drv_val;
    wire  [7:0]  nf_d;
    logic        sts;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    typedef enum {ViewArray, ViewStatus, ViewId} view_e;
    view_e       m_view;
    logic [7:0]  m_mem [256];
    logic        m_perr, m_eerr;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign nf_d = drv_en ? drv_val : 8'hzz;

    nor_flash_responder #(
        .PROG_CYCLES (ProgCycles),
        .ERASE_CYCLES(EraseCycles),
        .MFR_ID      (8'h89),
        .DEV_ID      (8'h16)
    ) dut (
        .CLK_50MHZ(clk),
        .RST      (rst),
        .NF_A     (addr),
        .NF_D     (nf_d),
        .NF_CE    (ce),
        .NF_OE    (oe),
        .NF_WE    (we),
        .NF_RP    (rp),
        .NF_WP    (wp),
        .NF_BYTE  (byte_n),
        .NF_STS   (sts)
    );

    function automatic logic [7:0] m_sr(input logic ready);
        return {ready, 1'b0, m_eerr, m_perr, 4'h0};
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (m_view)
            ViewArray:  return m_mem[a];
            ViewStatus: return m_sr(1'b1);
            default:    return (a == 8'd0) ? 8'h89 : ((a == 8'd1) ? 8'h16 : 8'h00);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; drv_val = d; drv_en = 1'b1; oe = 1'b1; ce = 1'b0; we = 1'b0;
        repeat (3) @(negedge clk);
        we = 1'b1;
        repeat (2) @(negedge clk);
        ce = 1'b1; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] q);
        @(negedge clk);
        addr = a; drv_en = 1'b0; we = 1'b1; ce = 1'b0; oe = 1'b0;
        repeat (3) @(negedge clk);
        q = nf_d;
        oe = 1'b1; ce = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a);
        logic [7:0] q;
        bus_read(a, q);
        check_eq(tag, 32'(q), 32'(m_read(a)));
    endtask

    // Command issued while the device sits in a read mode.
    task automatic cmd(input logic [7:0] c);
        bus_write(8'h00, c);
        case (c)
            8'hFF:   m_view = ViewArray;
            8'h70:   m_view = ViewStatus;
            8'h90:   m_view = ViewId;
            8'h50: begin
                m_perr = 1'b0;
                m_eerr = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic wait_sts(input string tag, input logic val, input int unsigned budget,
                            output int unsigned at);
        int unsigned i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (sts !== val && i < budget);
        at = cyc;
        check_eq(tag, 32'(sts), 32'(val));
    endtask

    task automatic do_program(input logic [7:0] a, input logic [7:0] d, input bit mid_read);
        int unsigned t0, t1;
        logic [7:0]  q;
        bus_write(8'h00, 8'h40);
        bus_write(a, d);
        if (wp) begin
            m_mem[a] = m_mem[a] & d;
            wait_sts("prog_busy", 1'b0, 6, t0);
            if (mid_read) begin
                bus_read(a, q);
                check_eq("prog_sr_busy", 32'(q), 32'(m_sr(1'b0)));
            end
            wait_sts("prog_ready", 1'b1, ProgCycles + 20, t1);
            check_eq("prog_len", t1 - t0, ProgCycles);
        end else begin
            m_perr = 1'b1;
            repeat (2) @(negedge clk);
            check_eq("prog_wp_sts", 32'(sts), 32'd1);
        end
        m_view = ViewStatus;
    endtask

    task automatic do_erase(input logic [7:0] conf, input int abort_at);
        int unsigned t0, t1;
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, conf);
        if (conf != 8'hD0) begin
            m_perr = 1'b1;
            m_eerr = 1'b1;
            m_view = ViewStatus;
        end else if (!wp) begin
            m_eerr = 1'b1;
            m_view = ViewStatus;
        end else begin
            wait_sts("erase_busy", 1'b0, 6, t0);
            if (abort_at >= 0) begin
                repeat (abort_at) @(negedge clk);
                rp = 1'b0;
                repeat (4) @(negedge clk);
                check_eq("abort_sts", 32'(sts), 32'd1);
                rp = 1'b1;
                repeat (4) @(negedge clk);
                // Two more walk steps land while NF_RP crosses the synchronizer.
                for (int i = 0; i < abort_at + 2; i++) m_mem[i] = 8'hFF;
                m_perr = 1'b0;
                m_eerr = 1'b0;
                m_view = ViewArray;
            end else begin
                wait_sts("erase_ready", 1'b1, EraseCycles + 20, t1);
                check_eq("erase_len", t1 - t0, EraseCycles);
                for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
                m_view = ViewStatus;
            end
        end
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a, d, c;
        logic [7:0] pre_addr [6];

        rst = 1'b1; addr = 8'h00; ce = 1'b1; oe = 1'b1; we = 1'b1; rp = 1'b1; wp = 1'b1;
        byte_n = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
        m_view = ViewArray; m_perr = 1'b0; m_eerr = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_sts", 32'(sts), 32'd1);
        for (int i = 0; i < 4; i++) read_check($sformatf("rst_rd_%0d", i), 8'(i));

        // With OE high the responder must not fight a bench-driven bus.
        @(negedge clk);
        ce = 1'b0; oe = 1'b1; we = 1'b1; drv_en = 1'b1; drv_val = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("hiz_oe", 32'(nf_d), 32'h00);
        drv_en = 1'b0; ce = 1'b1;

        cmd(8'h70);
        read_check("sr_reset", 8'h00);
        cmd(8'hFF);

        do_program(8'h12, 8'hA5, 1'b1);
        read_check("prog_sr", 8'h12);
        cmd(8'hFF);
        read_check("prog_rd", 8'h12);

        do_program(8'h12, 8'h5A, 1'b0);
        cmd(8'hFF);
        read_check("and_rule", 8'h12);

        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            do_program(a, d, 1'b0);
            cmd(8'hFF);
            read_check($sformatf("rand_prog_%0d", i), a);
        end

        do_erase(8'hD0, -1);
        read_check("erase_sr", 8'h00);
        cmd(8'hFF);
        for (int i = 0; i < 256; i++) read_check($sformatf("erase_rd_%0d", i), 8'(i));

        do_erase(8'h33, -1);
        read_check("erase_bad_sr", 8'h00);
        cmd(8'h50);
        read_check("clr_sr", 8'h00);

        wp = 1'b0;
        a = 8'($urandom_range(0, 255));
        do_program(a, 8'h00, 1'b0);
        read_check("wp_prog_sr", 8'h00);
        cmd(8'hFF);
        read_check("wp_mem", a);
        cmd(8'h90);
        read_check("id_0", 8'h00);
        read_check("id_1", 8'h01);
        read_check("id_2", 8'h02);
        do_erase(8'hD0, -1);
        read_check("wp_erase_sr", 8'h00);
        wp = 1'b1;

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 4))
                0:       c = 8'hFF;
                1:       c = 8'h70;
                2:       c = 8'h90;
                3:       c = 8'h50;
                default: begin
                    do c = 8'($urandom); while (c == 8'h40 || c == 8'h10 || c == 8'h20);
                end
            endcase
            cmd(c);
            a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            read_check($sformatf("cmd_%02h_%0d", c, i), a);
        end

        // Seed bytes on both sides of where the aborted walk stops.
        pre_addr[0] = 8'd10;  pre_addr[1] = 8'd200; pre_addr[2] = 8'd251;
        pre_addr[3] = 8'd252; pre_addr[4] = 8'd253; pre_addr[5] = 8'd255;
        for (int i = 0; i < 6; i++) do_program(pre_addr[i], 8'($urandom_range(0, 254)), 1'b0);
        cmd(8'hFF);
        do_erase(8'hD0, 250);
        read_check("abort_mode", 8'd252);
        cmd(8'h70);
        read_check("abort_sr", 8'h00);
        cmd(8'hFF);
        for (int i = 0; i < 256; i++) read_check($sformatf("abort_rd_%0d", i), 8'(i));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
